// File: rtl/rom_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter_if
// Bundle of every signal between the program-ROM arbiter, its two requesters
// (instruction fetch F, data load D) and the single-port ROM.
//
// Modports
//   slave  : the arbiter itself (takes requests and rom_data, drives grants,
//            responses and rom_address).
//   master : the environment around the arbiter (requesters plus the ROM).
//
// Signals
//   f_req/f_addr      fetch request and byte address
//   f_gnt             fetch request accepted this cycle (combinational)
//   f_rvalid/f_rdata  fetch response, one cycle after the grant
//   d_req/d_addr      data-load request and byte address
//   d_gnt             data request accepted this cycle (combinational)
//   d_rvalid/d_rdata  data response, one cycle after the grant
//   d_misalign        qualifies d_rvalid: the granted d_addr[1:0] was nonzero
//   rom_address       byte address presented to the ROM
//   rom_data          ROM read word, valid one cycle after the address edge
// -----------------------------------------------------------------------------
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_misalign;

    logic [ADDR_W-1:0] rom_address;
    logic [31:0]       rom_data;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, rom_data,
        output f_gnt, f_rvalid, f_rdata,
        output d_gnt, d_rvalid, d_rdata, d_misalign,
        output rom_address
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, rom_data,
        input  f_gnt, f_rvalid, f_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_misalign,
        input  rom_address
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
// Shares the single-port program ROM between instruction fetch (F) and the
// data load unit (D). At most one request is accepted per cycle; the winner's
// byte address goes straight to the ROM and the ROM word comes back to the
// winner exactly one cycle later.
//
// Arbitration: D has fixed priority, except that once F has been denied
// MAX_WAIT consecutive cycles it overrides D for one grant.
//
// Ports
//   clk      system clock, all state updates on its rising edge
//   reset_n  asynchronous active-low reset
//   bus      rom_port_arbiter_if.slave (requests, grants, responses, ROM side)
//
// Parameters
//   ADDR_W   ROM byte-address width
//   MAX_WAIT consecutive denied F cycles before F overrides D (1..15)
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rom_port_arbiter_if.slave      bus
);

    typedef enum logic {
        OWNER_F = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    // State
    logic [3:0]        r_wait_cnt;     // consecutive cycles F was denied
    owner_e            r_owner;        // port that owns the response in flight
    logic              r_resp_pending; // a grant happened on the last edge
    logic              r_misalign;     // last D grant used a non-word address
    logic [ADDR_W-1:0] r_hold_addr;    // last granted address, keeps ROM stable

    // Combinational decisions
    logic              w_f_starved;
    logic              w_f_gnt;
    logic              w_d_gnt;
    logic              w_any_gnt;
    logic [ADDR_W-1:0] w_rom_address;
    logic [3:0]        w_wait_cnt_nxt;

    // -------------------------------------------------------------------------
    // Grant and ROM address selection
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_f_starved   = bus.f_req && (r_wait_cnt == WAIT_LIMIT);
        w_f_gnt       = 1'b0;
        w_d_gnt       = 1'b0;
        w_rom_address = r_hold_addr;

        if (w_f_starved) begin
            w_f_gnt       = 1'b1;
            w_rom_address = bus.f_addr;
        end else if (bus.d_req) begin
            w_d_gnt       = 1'b1;
            w_rom_address = bus.d_addr;
        end else if (bus.f_req) begin
            w_f_gnt       = 1'b1;
            w_rom_address = bus.f_addr;
        end
    end

    assign w_any_gnt = w_f_gnt || w_d_gnt;

    // -------------------------------------------------------------------------
    // Starvation counter: counts F's denied cycles, saturating at MAX_WAIT.
    // Any F grant, or F dropping its request, starts the count over.
    // -------------------------------------------------------------------------
    always_comb begin
        w_wait_cnt_nxt = 4'd0;
        if (bus.f_req && !w_f_gnt) begin
            if (r_wait_cnt >= WAIT_LIMIT) begin
                w_wait_cnt_nxt = WAIT_LIMIT;
            end else begin
                w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt     <= 4'd0;
            r_owner        <= OWNER_F;
            r_resp_pending <= 1'b0;
            r_misalign     <= 1'b0;
            r_hold_addr    <= '0;
        end else begin
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_resp_pending <= w_any_gnt;
            // Only a D grant can produce a misaligned response; any other
            // cycle clears it, so it is never high without d_rvalid.
            r_misalign     <= w_d_gnt && (bus.d_addr[1:0] != 2'b00);
            if (w_any_gnt) begin
                r_owner     <= w_d_gnt ? OWNER_D : OWNER_F;
                r_hold_addr <= w_rom_address;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.f_gnt       = w_f_gnt;
    assign bus.d_gnt       = w_d_gnt;
    assign bus.rom_address = w_rom_address;

    assign bus.f_rvalid    = r_resp_pending && (r_owner == OWNER_F);
    assign bus.d_rvalid    = r_resp_pending && (r_owner == OWNER_D);
    assign bus.d_misalign  = r_misalign;

    // The ROM word is shared; each port qualifies it with its own rvalid.
    assign bus.f_rdata     = bus.rom_data;
    assign bus.d_rdata     = bus.rom_data;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_port_arbiter
// Directed scenarios followed by random traffic, all checked against a
// behavioural model of the arbiter and a synchronous ROM model.
// -----------------------------------------------------------------------------
module tb_rom_port_arbiter;

    localparam int ADDR_W   = 14;
    localparam int MAX_WAIT = 4;

    typedef enum int { P_NONE, P_F, P_D } port_e;

    logic clk;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    rom_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    rom_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known ROM content: word index -> distinct 32-bit value.
    function automatic logic [31:0] rom_word(input int unsigned idx);
        return (32'h1000_0000 + idx * 32'h0001_0101) ^ 32'h00A5_0000;
    endfunction

    // Synchronous ROM: word appears one cycle after the address edge and
    // ignores address bits [1:0].
    always @(posedge clk) begin
        bus.rom_data <= rom_word(32'(bus.rom_address >> 2));
    end

    // ---------------- reference model state ----------------
    int                m_streak;    // consecutive cycles F has been refused
    port_e             m_pend;      // who receives a response this cycle
    logic [ADDR_W-1:0] m_pend_addr; // address of that response
    logic [ADDR_W-1:0] m_hold;      // last address handed to the ROM
    logic              last_d_gnt;

    task automatic model_reset();
        m_streak    = 0;
        m_pend      = P_NONE;
        m_pend_addr = '0;
        m_hold      = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive requests after the falling edge, check the
    // combinational grant and the response owed from the previous cycle,
    // then advance the model.
    task automatic step(input logic fr, input logic [ADDR_W-1:0] fa,
                        input logic dr, input logic [ADDR_W-1:0] da);
        port_e             win;
        logic [ADDR_W-1:0] exp_addr;
        @(negedge clk);
        bus.f_req  = fr;
        bus.f_addr = fa;
        bus.d_req  = dr;
        bus.d_addr = da;
        #1;
        if (fr && m_streak >= MAX_WAIT) win = P_F;
        else if (dr)                    win = P_D;
        else if (fr)                    win = P_F;
        else                            win = P_NONE;
        exp_addr = (win == P_F) ? fa : (win == P_D) ? da : m_hold;

        check("f_gnt",       64'(bus.f_gnt),       64'(win == P_F));
        check("d_gnt",       64'(bus.d_gnt),       64'(win == P_D));
        check("rom_address", 64'(bus.rom_address), 64'(exp_addr));
        check("f_rvalid",    64'(bus.f_rvalid),    64'(m_pend == P_F));
        check("d_rvalid",    64'(bus.d_rvalid),    64'(m_pend == P_D));
        check("d_misalign",  64'(bus.d_misalign),
              64'(m_pend == P_D && m_pend_addr[1:0] != 2'b00));
        if (m_pend == P_F)
            check("f_rdata", 64'(bus.f_rdata), 64'(rom_word(32'(m_pend_addr >> 2))));
        if (m_pend == P_D)
            check("d_rdata", 64'(bus.d_rdata), 64'(rom_word(32'(m_pend_addr >> 2))));
        last_d_gnt = bus.d_gnt;

        if (fr && win != P_F) m_streak = (m_streak + 1 > MAX_WAIT) ? MAX_WAIT : m_streak + 1;
        else                  m_streak = 0;
        m_pend = win;
        if (win != P_NONE) begin
            m_pend_addr = exp_addr;
            m_hold      = exp_addr;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0);
    endtask

    // Safety net: the bench must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        bus.f_req  = 1'b0;
        bus.f_addr = '0;
        bus.d_req  = 1'b0;
        bus.d_addr = '0;
        model_reset();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_f_rvalid",   64'(bus.f_rvalid),    64'(0));
        check("rst_d_rvalid",   64'(bus.d_rvalid),    64'(0));
        check("rst_d_misalign", 64'(bus.d_misalign),  64'(0));
        check("rst_rom_addr",   64'(bus.rom_address), 64'(0));
        // Release just after a rising edge so the next cycle is the first
        // one with reset_n high, where a grant must already be possible.
        @(posedge clk); #2;
        reset_n = 1'b1;

        // ---- single fetch at 0x0010 ----
        step(1'b1, 14'h0010, 1'b0, '0);
        idle();
        check("t1_rdata_word4", 64'(bus.f_rdata), 64'(rom_word(4)));
        idle();

        // ---- both requesting continuously: D,D,D,D,F repeating ----
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 14'(32'h100 + 4 * i), 1'b1, 14'(32'h200 + 4 * i));
            check("pattern_d_gnt", 64'(last_d_gnt), 64'((i % 5) != 4));
        end
        idle();
        idle();

        // ---- alternating singles F@0, D@8, F@4, no bubbles ----
        step(1'b1, 14'h0000, 1'b0, '0);
        step(1'b0, '0, 1'b1, 14'h0008);
        step(1'b1, 14'h0004, 1'b0, '0);
        idle();
        idle();

        // ---- misaligned data load then an aligned one ----
        step(1'b0, '0, 1'b1, 14'h000A);
        step(1'b0, '0, 1'b1, 14'h000C);
        check("t4_misalign_word2", 64'(bus.d_rdata), 64'(rom_word(2)));
        idle();
        idle();

        // ---- reset between a grant and its response edge ----
        @(negedge clk);
        bus.f_req  = 1'b1;
        bus.f_addr = 14'h0030;
        #1;
        check("t5_f_gnt", 64'(bus.f_gnt), 64'(1));
        #1;
        reset_n   = 1'b0;
        bus.f_req = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("t5_f_rvalid_in_rst", 64'(bus.f_rvalid),    64'(0));
            check("t5_rom_addr_in_rst", 64'(bus.rom_address), 64'(0));
        end
        @(posedge clk); #2;
        reset_n = 1'b1;
        idle();
        idle();
        check("t5_rom_addr_idle", 64'(bus.rom_address), 64'(0));

        // ---- wait counter cleared by reset: D must win 4 times before F ----
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 14'h0040, 1'b1, 14'h0044);
            check("t5_post_rst_pattern", 64'(last_d_gnt), 64'(i != 4));
        end
        idle();
        idle();

        // ---- idle after a grant to 0x0020 holds the address ----
        step(1'b1, 14'h0020, 1'b0, '0);
        idle();
        idle();
        idle();
        check("t6_hold_addr", 64'(bus.rom_address), 64'(14'h0020));
        check("t6_no_rvalid", 64'(bus.f_rvalid | bus.d_rvalid), 64'(0));

        // ---- random traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            logic              fr;
            logic              dr;
            logic [ADDR_W-1:0] fa;
            logic [ADDR_W-1:0] da;
            fr = ($urandom_range(0, 9) < 6);
            dr = ($urandom_range(0, 9) < 5);
            fa = 14'($urandom) & ~14'h3;
            da = 14'($urandom);
            step(fr, fa, dr, da);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
